// File: rtl/cache_ctrl_pkg.sv
// Package: cache_ctrl_pkg
// Shared geometry, FSM state encoding and small helpers for the two-way
// write-through read cache (cache_ctrl) and its per-way storage (cache_way).
//   ADDR_W  byte-address width (addr[2] selects the word, addr[1:0] ignored)
//   IDX_W   set-index width, index = addr[IDX_W+2:3]
//   TAG_W   tag width, tag = addr[ADDR_W-1:IDX_W+3]
package cache_ctrl_pkg;

   localparam int ADDR_W = 18;
   localparam int IDX_W  = 6;
   localparam int TAG_W  = ADDR_W - IDX_W - 3;
   localparam int SETS   = 1 << IDX_W;
   localparam int WORD_W = 32;
   localparam int LINE_W = 64;
   localparam int N_WAYS = 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RMISS = 2'd1,
      S_WRITE = 2'd2
   } state_t;

   // Select one 32-bit word from a 64-bit line; word0 lives in the low half.
   function automatic logic [WORD_W-1:0] word_of(input logic [LINE_W-1:0] line,
                                                 input logic              sel);
      return sel ? line[63:32] : line[31:0];
   endfunction

endpackage

// File: rtl/cache_ctrl_way.sv
// Module: cache_way
// One way of the cache: per-set valid bit, tag and 64-bit line.
// Reads are combinational by index so a hit can complete in the request
// cycle; writes are synchronous. Only the valid bits are reset -- tag and
// data contents are meaningless while their valid bit is clear.
// Ports:
//   clk, rst     clock, synchronous active-high reset (clears valid bits)
//   idx          set index for both read and write
//   fill_en      write a whole line: valid<=1, tag<=fill_tag, data<=fill_data
//   fill_tag     tag written on a fill
//   fill_data    line written on a fill
//   word_wr_en   overwrite one word of the indexed line (valid/tag untouched)
//   word_sel     which word word_wr_en updates (1 = upper)
//   word_data    data for word_wr_en
//   valid/tag/data  combinational read of the indexed set
module cache_way
   import cache_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [IDX_W-1:0]  idx,
   input  logic              fill_en,
   input  logic [TAG_W-1:0]  fill_tag,
   input  logic [LINE_W-1:0] fill_data,
   input  logic              word_wr_en,
   input  logic              word_sel,
   input  logic [WORD_W-1:0] word_data,
   output logic              valid,
   output logic [TAG_W-1:0]  tag,
   output logic [LINE_W-1:0] data
);

   logic [SETS-1:0]   valid_reg;
   logic [TAG_W-1:0]  tag_mem  [SETS];
   logic [LINE_W-1:0] data_mem [SETS];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg <= '0;
      end else if (fill_en) begin
         valid_reg[idx] <= 1'b1;
      end
   end

   // Storage arrays carry no reset so they can map onto RAM resources.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_mem[idx]  <= fill_tag;
         data_mem[idx] <= fill_data;
      end else if (word_wr_en) begin
         if (word_sel) begin
            data_mem[idx][63:32] <= word_data;
         end else begin
            data_mem[idx][31:0] <= word_data;
         end
      end
   end

   assign valid = valid_reg[idx];
   assign tag   = tag_mem[idx];
   assign data  = data_mem[idx];

endmodule

// File: rtl/cache_ctrl.sv
// Module: cache_ctrl
// Two-way set-associative, write-through, no-write-allocate read cache
// between the MEM stage and the SRAM controller. Read hits complete in the
// request cycle; read misses fetch a 64-bit line; every store goes to SRAM
// and only updates the cache when it hits. The MEM stage freezes on ~ready
// and holds addr/wdata, so updates on the completing edge happen once.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   addr, wdata            request address / store data from MEM stage
//   MEM_R_en, MEM_W_en     load / store request (both high = store)
//   rdata                  load data, valid when MEM_R_en & ready
//   ready                  request completes this cycle
//   sram_addr, sram_wdata  pass-through of addr / wdata to SRAM controller
//   sram_r_en, sram_w_en   line fetch / write-through request, held to sram_ready
//   sram_rdata             fetched line, [31:0] = word0, [63:32] = word1
//   sram_ready             SRAM access completes this cycle
module cache_ctrl
   import cache_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   input  logic              MEM_R_en,
   input  logic              MEM_W_en,
   output logic [WORD_W-1:0] rdata,
   output logic              ready,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [WORD_W-1:0] sram_wdata,
   output logic              sram_r_en,
   output logic              sram_w_en,
   input  logic [LINE_W-1:0] sram_rdata,
   input  logic              sram_ready
);

   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag_in;
   logic             word_sel;

   assign idx      = addr[IDX_W+2:3];
   assign tag_in   = addr[ADDR_W-1:IDX_W+3];
   assign word_sel = addr[2];

   logic [N_WAYS-1:0] way_valid;
   logic [N_WAYS-1:0] way_hit;
   logic [N_WAYS-1:0] fill_en;
   logic [N_WAYS-1:0] word_wr_en;
   logic [TAG_W-1:0]  way_tag  [N_WAYS];
   logic [LINE_W-1:0] way_data [N_WAYS];

   generate
      for (genvar gi = 0; gi < N_WAYS; gi++) begin : g_way
         cache_way u_way (
            .clk        (clk),
            .rst        (rst),
            .idx        (idx),
            .fill_en    (fill_en[gi]),
            .fill_tag   (tag_in),
            .fill_data  (sram_rdata),
            .word_wr_en (word_wr_en[gi]),
            .word_sel   (word_sel),
            .word_data  (wdata),
            .valid      (way_valid[gi]),
            .tag        (way_tag[gi]),
            .data       (way_data[gi])
         );
         assign way_hit[gi] = way_valid[gi] && (way_tag[gi] == tag_in);
      end
   endgenerate

   // At most one way can hit, so the way-1 hit bit doubles as the hit way.
   logic              hit;
   logic              hit_way;
   logic [LINE_W-1:0] hit_data;
   logic              victim_way;

   // LRU bit per set names the way to evict next.
   logic [SETS-1:0] lru_reg;
   logic            lru_we;
   logic            lru_val;

   assign hit      = |way_hit;
   assign hit_way  = way_hit[1];
   assign hit_data = hit_way ? way_data[1] : way_data[0];

   // Empty ways are filled first (way0 before way1); LRU only decides
   // once both ways of the set hold a line.
   assign victim_way = !way_valid[0] ? 1'b0 :
                       !way_valid[1] ? 1'b1 : lru_reg[idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         lru_reg <= '0;
      end else if (lru_we) begin
         lru_reg[idx] <= lru_val;
      end
   end

   state_t state_reg, state_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // All array strobes are only raised in a cycle where ready=1, and never
   // while rst is high, so an abandoned access leaves the arrays untouched.
   always_comb begin
      state_next = state_reg;
      ready      = 1'b0;
      sram_r_en  = 1'b0;
      sram_w_en  = 1'b0;
      rdata      = word_of(hit_data, word_sel);
      fill_en    = '0;
      word_wr_en = '0;
      lru_we     = 1'b0;
      lru_val    = 1'b0;
      if (!rst) begin
         case (state_reg)
            S_IDLE: begin
               if (MEM_W_en) begin
                  sram_w_en  = 1'b1;
                  state_next = S_WRITE;
               end else if (MEM_R_en) begin
                  if (hit) begin
                     ready   = 1'b1;
                     lru_we  = 1'b1;
                     lru_val = ~hit_way;
                  end else begin
                     sram_r_en  = 1'b1;
                     state_next = S_RMISS;
                  end
               end else begin
                  ready = 1'b1;
               end
            end
            S_RMISS: begin
               sram_r_en = 1'b1;
               rdata     = word_of(sram_rdata, word_sel);
               if (sram_ready) begin
                  ready      = 1'b1;
                  fill_en    = {victim_way, ~victim_way};
                  lru_we     = 1'b1;
                  lru_val    = ~victim_way;
                  state_next = S_IDLE;
               end
            end
            S_WRITE: begin
               sram_w_en = 1'b1;
               if (sram_ready) begin
                  ready      = 1'b1;
                  word_wr_en = way_hit;
                  state_next = S_IDLE;
               end
            end
            default: begin
               state_next = S_IDLE;
            end
         endcase
      end
   end

   assign sram_addr  = addr;
   assign sram_wdata = wdata;

endmodule

// File: tb/tb_cache_ctrl.sv
// Testbench: tb_cache_ctrl
// Directed scenarios followed by randomized traffic against a reference
// model that tracks each set as a recency-ordered list of resident lines
// (MRU first, at most two) plus a flat expected memory image.
module tb_cache_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [17:0] addr;
   logic [31:0] wdata;
   logic        MEM_R_en;
   logic        MEM_W_en;
   logic [31:0] rdata;
   logic        ready;
   logic [17:0] sram_addr;
   logic [31:0] sram_wdata;
   logic        sram_r_en;
   logic        sram_w_en;
   logic [63:0] sram_rdata;
   logic        sram_ready;

   always #5 clk = ~clk;

   cache_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .addr       (addr),
      .wdata      (wdata),
      .MEM_R_en   (MEM_R_en),
      .MEM_W_en   (MEM_W_en),
      .rdata      (rdata),
      .ready      (ready),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_r_en  (sram_r_en),
      .sram_w_en  (sram_w_en),
      .sram_rdata (sram_rdata),
      .sram_ready (sram_ready)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [63:0] init_line(input int ln);
      logic [31:0] x;
      x = ln;
      return {(x * 32'h9E3779B1) ^ 32'h5A5A0000, (x + 32'h1357) * 32'h85EBCA6B};
   endfunction

   function automatic logic [63:0] merge_word(input logic [63:0] line, input logic sel,
                                              input logic [31:0] wd);
      logic [63:0] r;
      r = line;
      if (sel) r[63:32] = wd;
      else     r[31:0]  = wd;
      return r;
   endfunction

   // ---------------- SRAM controller model: ready in 4th enabled cycle
   logic [63:0] sram_mem [32768];
   bit          sram_wr  [32768];
   logic [1:0]  sram_cnt = 2'd0;

   function automatic logic [63:0] sram_line(input int ln);
      return sram_wr[ln] ? sram_mem[ln] : init_line(ln);
   endfunction

   assign sram_ready = (sram_r_en || sram_w_en) && (sram_cnt == 2'd3);

   always @(posedge clk) begin
      if (rst || !(sram_r_en || sram_w_en) || sram_ready) sram_cnt <= 2'd0;
      else sram_cnt <= sram_cnt + 2'd1;
      if (!rst && sram_w_en && sram_ready) begin
         sram_mem[int'(sram_addr[17:3])] <= merge_word(sram_line(int'(sram_addr[17:3])),
                                                       sram_addr[2], sram_wdata);
         sram_wr[int'(sram_addr[17:3])]  <= 1'b1;
      end
      sram_rdata <= sram_line(int'(sram_addr[17:3]));
   end

   // ---------------- reference model
   typedef struct {
      logic [8:0]  tag;
      logic [63:0] data;
   } line_t;

   line_t       set_q   [64][$];
   logic [63:0] ref_mem [32768];
   bit          ref_wr  [32768];

   function automatic logic [63:0] ref_line(input int ln);
      return ref_wr[ln] ? ref_mem[ln] : init_line(ln);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 64; i++) set_q[i].delete();
   endtask

   task automatic model_access(input logic [17:0] a, input bit w, input logic [31:0] wd,
                               output bit miss, output logic [31:0] exp_word);
      int    s;
      int    ln;
      int    pos;
      line_t e;
      s   = int'(a[8:3]);
      ln  = int'(a[17:3]);
      pos = -1;
      for (int i = 0; i < set_q[s].size(); i++)
         if (set_q[s][i].tag == a[17:9]) pos = i;
      miss     = 1'b0;
      exp_word = '0;
      if (w) begin
         ref_mem[ln] = merge_word(ref_line(ln), a[2], wd);
         ref_wr[ln]  = 1'b1;
         if (pos >= 0) begin
            e = set_q[s][pos];
            e.data = merge_word(e.data, a[2], wd);
            set_q[s][pos] = e;
         end
      end else begin
         if (pos >= 0) begin
            e = set_q[s][pos];
            set_q[s].delete(pos);
         end else begin
            miss   = 1'b1;
            e.tag  = a[17:9];
            e.data = ref_line(ln);
         end
         set_q[s].push_front(e);
         if (set_q[s].size() > 2) void'(set_q[s].pop_back());
         exp_word = a[2] ? e.data[63:32] : e.data[31:0];
      end
   endtask

   // ---------------- one transaction, checked against the model
   task automatic do_req(input logic [17:0] a, input bit r, input bit w, input logic [31:0] wd,
                         input string nm, output int lat, output logic [31:0] got);
      bit          miss;
      logic [31:0] exp_word;
      int          n_r;
      int          n_w;
      model_access(a, w, wd, miss, exp_word);
      addr = a; wdata = wd; MEM_R_en = r; MEM_W_en = w;
      lat = 0; n_r = 0; n_w = 0; got = '0;
      do begin
         @(negedge clk);
         lat++;
         if (sram_r_en) n_r++;
         if (sram_w_en) n_w++;
         got = rdata;
      end while (!ready && lat < 20);
      check_val({nm, "_lat"}, 64'(lat), (w || miss) ? 64'd4 : 64'd1);
      check_val({nm, "_rcnt"}, 64'(n_r), (!w && miss) ? 64'd4 : 64'd0);
      check_val({nm, "_wcnt"}, 64'(n_w), w ? 64'd4 : 64'd0);
      check_val({nm, "_saddr"}, 64'(sram_addr), 64'(a));
      if (w) check_val({nm, "_swdata"}, 64'(sram_wdata), 64'(wd));
      else   check_val({nm, "_rdata"}, 64'(got), 64'(exp_word));
      $display("txn %s addr=%05h r=%0d w=%0d lat=%0d rdata=%08h", nm, a, r, w, lat, got);
      @(posedge clk); #1;
      MEM_R_en = 1'b0; MEM_W_en = 1'b0;
   endtask

   task automatic idle_cycle(input string nm);
      MEM_R_en = 1'b0; MEM_W_en = 1'b0;
      @(negedge clk);
      check_val({nm, "_rdy"}, 64'(ready), 64'd1);
      check_val({nm, "_en"}, {62'd0, sram_r_en, sram_w_en}, 64'd0);
      $display("txn %s idle ready=%0d", nm, ready);
      @(posedge clk); #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic [31:0] got;
      logic [17:0] a;
      int          op;

      // Reset with a load pending: nothing may be requested or completed.
      rst = 1'b1; addr = 18'h00040; wdata = '0; MEM_R_en = 1'b1; MEM_W_en = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_ready", 64'(ready), 64'd0);
      check_val("rst_en", {62'd0, sram_r_en, sram_w_en}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0; MEM_R_en = 1'b0;
      model_clear();
      idle_cycle("t0_idle");

      // 1/2: cold miss, hit on refetch, hit on the other word of the line.
      do_req(18'h00040, 1, 0, 0, "t1_miss", lat, got);
      check_val("t1_miss_lat4", 64'(lat), 64'd4);
      do_req(18'h00040, 1, 0, 0, "t1_hit", lat, got);
      check_val("t1_hit_lat1", 64'(lat), 64'd1);
      do_req(18'h00044, 1, 0, 0, "t2_upper", lat, got);
      check_val("t2_upper_word", 64'(got), 64'(init_line(8) >> 32));

      // 3: three tags in set 8; third evicts tag 0.
      do_req(18'h00240, 1, 0, 0, "t3_a", lat, got);
      do_req(18'h00440, 1, 0, 0, "t3_b", lat, got);
      do_req(18'h00240, 1, 0, 0, "t3_hit", lat, got);
      check_val("t3_hit_lat1", 64'(lat), 64'd1);
      do_req(18'h00040, 1, 0, 0, "t3_evicted", lat, got);
      check_val("t3_evicted_lat4", 64'(lat), 64'd4);

      // 4: store hit updates the line; store miss does not allocate.
      do_req(18'h00240, 0, 1, 32'hDEADBEEF, "t4_st_hit", lat, got);
      do_req(18'h00240, 1, 0, 0, "t4_ld", lat, got);
      check_val("t4_ld_data", 64'(got), 64'hDEADBEEF);
      check_val("t4_ld_lat1", 64'(lat), 64'd1);
      do_req(18'h01000, 0, 1, 32'h12345678, "t4_st_miss", lat, got);
      do_req(18'h01000, 1, 0, 0, "t4_noalloc", lat, got);
      check_val("t4_noalloc_lat4", 64'(lat), 64'd4);
      check_val("t4_noalloc_data", 64'(got), 64'h12345678);

      // 5: both enables high is a store only.
      do_req(18'h00044, 1, 1, 32'hCAFEF00D, "t5_both", lat, got);
      do_req(18'h00044, 1, 0, 0, "t5_ld", lat, got);

      // 6: reset in the second cycle of a miss abandons it and clears valids.
      addr = 18'h00C40; MEM_R_en = 1'b1; MEM_W_en = 1'b0;
      @(negedge clk);
      check_val("t6_c1_ren", 64'(sram_r_en), 64'd1);
      check_val("t6_c1_rdy", 64'(ready), 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check_val("t6_rst_ren", 64'(sram_r_en), 64'd0);
      check_val("t6_rst_rdy", 64'(ready), 64'd0);
      $display("txn t6_rst addr=%05h ready=%0d sram_r_en=%0d", addr, ready, sram_r_en);
      @(posedge clk); #1;
      rst = 1'b0;
      model_clear();
      do_req(18'h00C40, 1, 0, 0, "t6_again", lat, got);
      check_val("t6_again_lat4", 64'(lat), 64'd4);
      do_req(18'h00040, 1, 0, 0, "t6_cleared", lat, got);
      check_val("t6_cleared_lat4", 64'(lat), 64'd4);

      // Randomized traffic over a few sets and tags to force reuse/eviction.
      for (int i = 0; i < 250; i++) begin
         a  = {9'($urandom_range(0, 3)), 6'($urandom_range(6, 9)), 1'($urandom), 2'($urandom)};
         op = $urandom_range(0, 19);
         if (op < 11)      do_req(a, 1, 0, 0, $sformatf("rnd%0d_ld", i), lat, got);
         else if (op < 16) do_req(a, 0, 1, $urandom, $sformatf("rnd%0d_st", i), lat, got);
         else if (op < 18) idle_cycle($sformatf("rnd%0d", i));
         else              do_req(a, 1, 1, $urandom, $sformatf("rnd%0d_rw", i), lat, got);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
